// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: accepts a key/plaintext pair, steps the shared core
// state bus through AddRoundKey, nine middle rounds and the final round, then holds the ciphertext.
package aes_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT_ADD_KEY,
    S_PROCESS_ROUNDS,
    S_FINAL_ROUND
  } aes_core_state_t;
endpackage

module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [127:0]    in_pt_i,
  input  logic [127:0]    in_key_i,
  output aes_core_state_t core_state_o,
  output logic [127:0]    core_key_o,
  output logic [127:0]    core_pt_o,
  output logic [3:0]      round_o,
  input  logic [127:0]    ct_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [127:0]    out_ct_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_ROUNDS,
    ST_FINAL,
    ST_DONE,
    ST_HOLD
  } state_t;

  state_t       state_reg, state_next;
  logic [3:0]   round_reg, round_next;
  logic [127:0] key_reg, pt_reg, ct_reg;
  logic         accept;

  // HOLD only offers a slot while the consumer is draining the current result.
  assign in_ready_o = !rst && ((state_reg == ST_IDLE) ||
                               (state_reg == ST_HOLD && out_ready_i));
  assign accept     = in_valid_i && in_ready_o && !clear_i;

  always_comb begin
    state_next = state_reg;
    round_next = 4'd0;
    if (clear_i) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state_reg)
        ST_IDLE:  if (accept) state_next = ST_LOAD;
        ST_LOAD:  state_next = ST_INIT;
        ST_INIT: begin
          state_next = ST_ROUNDS;
          round_next = 4'd1;
        end
        ST_ROUNDS: begin
          round_next = round_reg + 4'd1;
          if (round_reg == 4'(NR - 1)) state_next = ST_FINAL;
        end
        ST_FINAL: state_next = ST_DONE;
        ST_DONE:  state_next = ST_HOLD;
        ST_HOLD: begin
          if (out_ready_i) state_next = accept ? ST_LOAD : ST_IDLE;
        end
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      round_reg <= 4'd0;
      key_reg   <= '0;
      pt_reg    <= '0;
      ct_reg    <= '0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
      if (accept) begin
        key_reg <= in_key_i;
        pt_reg  <= in_pt_i;
      end
      // Datapath result settles on the FINAL edge, so it is sampled leaving DONE.
      if (!clear_i && state_reg == ST_DONE) ct_reg <= ct_i;
    end
  end

  always_comb begin
    core_state_o = S_IDLE;
    unique case (state_reg)
      ST_INIT:   core_state_o = S_INIT_ADD_KEY;
      ST_ROUNDS: core_state_o = S_PROCESS_ROUNDS;
      ST_FINAL:  core_state_o = S_FINAL_ROUND;
      default:   core_state_o = S_IDLE;
    endcase
  end

  assign core_key_o  = key_reg;
  assign core_pt_o   = pt_reg;
  assign round_o     = round_reg;
  assign out_valid_o = (state_reg == ST_HOLD);
  assign out_ct_o    = ct_reg;
  assign busy_o      = (state_reg != ST_IDLE);

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencing controller for the AES-128 encryption core. It accepts a plaintext and key pair over a valid/ready handshake and drives the `aes_core_state_t` state bus shared by the key schedule and the round datapath. It times the initial AddRoundKey, nine middle rounds and the final round, then captures the ciphertext and returns it over a backpressured output handshake. It sits between the block-level stream interface and the core datapath.

## Interface
- `NR`, default 10: number of cipher rounds. Only 10 is legal, because the key schedule holds exactly 10 round constants.
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clear_i` input 1: synchronous abort.
- `in_valid_i` input 1: input block offered.
- `in_ready_o` output 1: controller can accept a block.
- `in_pt_i` input 128: plaintext.
- `in_key_i` input 128: cipher key.
- `core_state_o` output `aes_core_state_t`: state bus to the key schedule and datapath.
- `core_key_o` output 128: registered key. Drives the key schedule key input.
- `core_pt_o` output 128: registered plaintext. The datapath loads it during S_INIT_ADD_KEY.
- `round_o` output 4: current round index, 0..NR.
- `ct_i` input 128: datapath state register, i.e. the ciphertext source.
- `out_valid_o` output 1: ciphertext available.
- `out_ready_i` input 1: consumer accepts the ciphertext.
- `out_ct_o` output 128: captured ciphertext.
- `busy_o` output 1: a block is in flight, in any state except IDLE.

## Operation
- Internal FSM states: IDLE, LOAD, INIT, ROUNDS, FINAL, DONE, HOLD.
- `core_state_o` mapping:
  - IDLE, LOAD, DONE and HOLD drive S_IDLE.
  - INIT drives S_INIT_ADD_KEY.
  - ROUNDS drives S_PROCESS_ROUNDS.
  - FINAL drives S_FINAL_ROUND.
- IDLE:
  - `in_ready_o`=1.
  - On `in_valid_i`&`in_ready_o`: key_reg<=`in_key_i`, pt_reg<=`in_pt_i`, go to LOAD.
- LOAD: one cycle with S_IDLE on the bus while key_reg is already stable. The key schedule samples round key 0 from `core_key_o` here. Next state is INIT.
- INIT: one cycle, round_o=0. The datapath performs AddRoundKey with key 0; the key schedule advances to key 1. Next state is ROUNDS with round counter set to 1.
- ROUNDS:
  - Runs NR-1 = 9 cycles; round_o runs 1..9 and increments every cycle.
  - When round_o=NR-1, next state is FINAL.
- FINAL: one cycle, round_o=NR. Next state is DONE.
- DONE: one cycle. ct_reg<=`ct_i`, which is valid after the FINAL edge. Next state is HOLD.
- HOLD:
  - `out_valid_o`=1 and `out_ct_o`=ct_reg, both stable until accepted.
  - On `out_ready_i`: if `in_valid_i` is also 1, accept the new block (`in_ready_o`=1 in HOLD only while `out_ready_i`=1) and go to LOAD; else go to IDLE.
- `round_o`: a 4-bit counter, zero in IDLE, LOAD, DONE and HOLD. It never exceeds NR and never wraps.
- `clear_i`:
  - In any state: go to IDLE next cycle, `out_valid_o` drops, round counter clears.
  - key_reg, pt_reg and ct_reg keep their values.
  - `clear_i` has priority over any handshake in the same cycle; no block is accepted in that cycle.
- `in_valid_i` while busy is ignored (`in_ready_o`=0). The producer holds its data per the standard valid/ready rules.

## Timing
- Reset state (asynchronous on `rst`=1):
  - FSM in IDLE, `core_state_o`=S_IDLE.
  - `in_ready_o`=1 once `rst` deasserts. While `rst`=1, `in_ready_o` is driven 0.
  - `out_valid_o`=0, `busy_o`=0, `round_o`=0.
  - key_reg, pt_reg and ct_reg are all 0.
- Reset mid-block: abandon the block immediately. No ciphertext is emitted.
- Latency, with the accept edge as cycle 0:
  - LOAD = cycle 1, INIT = 2, ROUNDS = 3..11, FINAL = 12, DONE = 13.
  - `out_valid_o` first high in cycle 14.
- Throughput with `out_ready_i` held 1 and `in_valid_i` held 1: one block per 14 cycles. The accept happens in the HOLD cycle itself.
- All outputs are registered or decoded from the state register only. No combinational path runs from `in_valid_i` or `out_ready_i` to any output except `in_ready_o` in HOLD.

## Test plan
- FIPS-197 C.1 vector: key 000102…0f, pt 00112233…ff, `out_ready_i`=1.
  - Required: `out_ct_o`=69c4e0d86a7b0430d8cdb78070b4c55a with `out_valid_o` first high at cycle 14.
  - Required bus sequence: S_IDLE, S_INIT_ADD_KEY, 9× S_PROCESS_ROUNDS, S_FINAL_ROUND.
- Backpressure: hold `out_ready_i`=0 for 20 cycles after `out_valid_o`.
  - Required: `out_ct_o` stable, `in_ready_o`=0, `busy_o`=1.
  - Release `out_ready_i` → IDLE next cycle.
- Back-to-back: two FIPS-197 Appendix B blocks (key 2b7e1516…, pt 3243f6a8…) with `in_valid_i` held.
  - Required: second accept in the first HOLD cycle.
  - Required: both outputs = 3925841d02dc09fbdc118597196a0b32, 14 cycles apart.
- Abort: `clear_i` pulse at cycle 7.
  - Required: IDLE with `round_o`=0 next cycle and no `out_valid_o`.
  - A following block produces the correct ciphertext.
- Async reset: assert `rst` mid-ROUNDS between clock edges.
  - Required: outputs reach reset values without waiting for a clock edge, and `round_o`=0.
- Simultaneous events: in IDLE, assert `in_valid_i` and `clear_i` together.
  - Required: no accept, FSM stays in IDLE.
